// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N_CH-input round-robin arbitrated multiplexer with valid/ready
// handshakes on every channel. The winning word is held in a single output
// register. Full throughput is kept by allowing a load in the same cycle the
// consumer drains the register.
module rr_arb_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam int SUM_W = SEL_W + 1;

    logic [SEL_W-1:0] ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;

    logic [SEL_W-1:0] grant_s;
    logic [SUM_W-1:0] scan_sum_s;
    logic [SEL_W-1:0] scan_idx_s;
    logic             can_load_s;
    logic [N_CH-1:0]  in_ready_s;
    logic             in_xfer_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [SEL_W-1:0] ptr_nxt_s;

    // Round-robin scan: walk offsets from farthest to nearest so the channel
    // closest to ptr (in modulo order) is the last writer and wins.
    always_comb begin
        grant_s    = '0;
        scan_sum_s = '0;
        scan_idx_s = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            scan_sum_s = {1'b0, ptr_r} + SUM_W'(k);
            if (scan_sum_s >= SUM_W'(N_CH)) begin
                scan_sum_s = scan_sum_s - SUM_W'(N_CH);
            end else begin
                scan_sum_s = scan_sum_s;
            end
            scan_idx_s = scan_sum_s[SEL_W-1:0];
            if (in_valid[scan_idx_s]) begin
                grant_s = scan_idx_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Handshake: only the granted, valid channel sees ready, and only when the
    // output register is empty or being drained this cycle (no skid buffer).
    always_comb begin
        can_load_s = ~out_valid_r | out_ready;
        in_ready_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready_s[i] = (grant_s == SEL_W'(i)) & in_valid[i] & can_load_s & ~rst;
        end
        in_xfer_s = |in_ready_s;
    end

    // Data select of the granted channel and the post-grant pointer, which
    // wraps explicitly so non-power-of-two channel counts fold back to 0.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_s == SEL_W'(i)) begin
                sel_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        if (grant_s == SEL_W'(N_CH - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_s + SEL_W'(1);
        end
    end

    // Output register and priority pointer; a load takes precedence over a
    // plain drain so a simultaneous load/drain replaces the word back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            ptr_r       <= '0;
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_sel_r   <= grant_s;
            ptr_r       <= ptr_nxt_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule
